bcd_counter_n: RTL
==================

Name: bcd_counter_n

Overview:
- Parametrised multi-digit BCD up/down counter with per-digit active-low 7-segment decode.
- Successor to the single-digit scoreboard digit counter: adds N-digit cascade, down-count, parallel load, synchronous clear, wrap/saturate mode and leading-zero blanking.
- Sits between game/control logic (increment, decrement and load strobes) and the HEX display pins.
- carryOut/borrowOut allow instances to be cascaded.

Parameters:
- DIGITS, 2, number of BCD digits (1..6); digit 0 is least significant.
- WRAP, 1, 1 = wrap 99..9 <-> 00..0; 0 = saturate at the ends.
- LZ_BLANK, 0, 1 = blank leading-zero digits on HEX.

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  synchronous, active-low; 0 at posedge clears the counter.
- clear  input  1  synchronous soft clear to zero, active-high.
- hold  input  1  freeze count; incr/decr ignored.
- incr  input  1  count up by 1 this cycle.
- decr  input  1  count down by 1 this cycle.
- load  input  1  load loadVal this cycle.
- loadVal  input  4*DIGITS  BCD value to load; digit i at [4i+3:4i].
- count  output  4*DIGITS  current BCD count, registered.
- HEX  output  7*DIGITS  active-low segments; digit i at [7i+6:7i].
- carryOut  output  1  combinational; an effective increment occurs at all-9s.
- borrowOut  output  1  combinational; an effective decrement occurs at all-0s.

Behaviour:
Reset and priority:
- Reset value: count = 0.
- HEX after reset = digit 0 shows "0" (7'b1000000). Higher digits show "0", or 7'b1111111 if LZ_BLANK=1.
- carryOut = borrowOut = 0 while reset = 0.
- Per-posedge priority: reset==0 > clear > load > hold > incr/decr.
- Effective increment: incr & ~decr & ~hold & ~load & ~clear & reset. Effective decrement is the mirror condition.
- incr & decr both asserted: no change, no carry or borrow.

Load:
- Result is registered; count equals loadVal on the cycle after load.
- A loaded digit > 9 is stored as 0. The other digits load normally.

Increment:
- Digit 0 +1. A digit at 9 rolls to 0 and carries into the next digit (ripple within one cycle).
- At all-9s:
  - WRAP=1: count becomes 0.
  - WRAP=0: count stays at all-9s.
  - carryOut = 1 in both modes (overflow/cascade indicator).

Decrement:
- Mirror of increment: a digit at 0 rolls to 9 and borrows.
- At all-0s:
  - WRAP=1: count becomes all-9s.
  - WRAP=0: count stays at 0.
  - borrowOut = 1 in both modes.

Cascade outputs:
- carryOut/borrowOut are combinational from the registered count and the current inputs, with no cycle delay.
- The downstream instance connects carryOut to incr and borrowOut to decr.

HEX decode (count is registered, so HEX is valid the same cycle as count):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
- Any other code = 1111111.

Leading-zero blanking (LZ_BLANK=1):
- Digit i>0 is blanked (1111111) when it and all higher digits are 0.
- Digit 0 is never blanked.

Other rules:
- hold with load or clear: load/clear still win.
- Reset asserted mid-count: zero on that posedge, regardless of other inputs.

Test Plan:
- DIGITS=2, WRAP=1. Reset low one cycle, then incr for 100 cycles -> count steps 00..99, then 00. carryOut=1 only in the cycle count==99; HEX[6:0] tracks the table.
- Reset, then decr for one cycle -> count=99 (8'h99), borrowOut=1 in that cycle; with WRAP=0 -> count stays 00, borrowOut=1.
- load=1, loadVal=8'h47 -> count=47 next cycle. Then hold=1 with incr=1 for 5 cycles -> count stays 47, carryOut=0. Then load with loadVal=8'h4C -> count=40.
- count=58, incr=decr=1 -> unchanged. Then clear=1 with incr=1 -> count=00. Then incr with reset=0 in the same cycle -> count=00, no carry.
- WRAP=0, count=99, incr for 3 cycles -> count stays 99, carryOut=1 each cycle.
- LZ_BLANK=1, count=05 -> HEX[13:7]=1111111, HEX[6:0]=0010010; count=00 -> HEX[6:0]=1000000, upper digit blank; count=30 -> both digits shown.

Source files
------------

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: multi-digit BCD up/down counter with per-digit active-low
// 7-segment decode, parallel load, soft clear, wrap/saturate ends and
// optional leading-zero blanking. carryOut/borrowOut allow cascading.
module bcd_counter_n #(
    parameter int DIGITS   = 2,     // 1..6, digit 0 is least significant
    parameter bit WRAP     = 1'b1,  // 1 = wrap at the ends, 0 = saturate
    parameter bit LZ_BLANK = 1'b0   // 1 = blank leading-zero digits
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  hold,
    input  logic                  incr,
    input  logic                  decr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   loadVal,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  carryOut,
    output logic                  borrowOut
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic         eff_inc;
    logic         eff_dec;
    logic         at_all9;
    logic         at_all0;
    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic [W-1:0] load_clean;
    logic [W-1:0] count_d;

    // Active-low segment pattern for one BCD digit; non-BCD codes go dark.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Effective count strobes: anything of higher priority masks them, and
    // incr together with decr cancels out.
    always_comb begin
        at_all9   = (count == ALL_NINES);
        at_all0   = (count == '0);
        eff_inc   = reset & ~clear & ~load & ~hold & incr & ~decr;
        eff_dec   = reset & ~clear & ~load & ~hold & decr & ~incr;
        carryOut  = eff_inc & at_all9;
        borrowOut = eff_dec & at_all0;
    end

    // Ripple +1 / -1 across all digits in one cycle, and sanitise the load
    // value so an out-of-range digit is stored as 0.
    always_comb begin
        logic c;
        logic b;
        // NOTE: every combinational output gets a default before any
        // conditional update, so no path leaves it unassigned (no latch).
        inc_val    = count;
        dec_val    = count;
        load_clean = loadVal;
        c          = 1'b1;
        b          = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (count[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
            if (b) begin
                if (count[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
            if (loadVal[4*i +: 4] > 4'd9) begin
                load_clean[4*i +: 4] = 4'd0;
            end
        end
    end

    // Next count by priority clear > load > hold > incr/decr; ends either
    // wrap (ripple result) or saturate (keep current value).
    always_comb begin
        count_d = count;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clean;
        end else if (eff_inc) begin
            count_d = (at_all9 && !WRAP) ? count : inc_val;
        end else if (eff_dec) begin
            count_d = (at_all0 && !WRAP) ? count : dec_val;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of evaluation order.
        if (!reset) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

    // Segment decode with optional blanking of leading zeros (digit 0 is
    // always shown); scanned from the top digit down.
    always_comb begin
        logic zero_above;
        HEX        = '1;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (count[4*i +: 4] == 4'd0);
            if (LZ_BLANK && (i > 0) && zero_above) begin
                HEX[7*i +: 7] = 7'b1111111;
            end else begin
                HEX[7*i +: 7] = seg7(count[4*i +: 4]);
            end
        end
    end

endmodule
